// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer: opcodes,
// FSM states and the packed command word carried through the FIFO.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_ROT = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam logic [7:0] DIV0_RESULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } alu_cmd_t;

  localparam int CMD_W = $bits(alu_cmd_t);

  function automatic logic is_div0(input logic [2:0] op, input logic [3:0] b);
    return (op == OP_DIV) && (b == 4'd0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with a fall-through head; push/pop are ignored
// when full/empty so callers may drive them from raw requests.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [CMD_W-1:0] push_data,
  input  logic             pop,
  output logic [CMD_W-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == LVL_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign level    = count_reg;
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr_reg];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time to a combinational ALU and
// returns registered results over valid/ready. ALU_SEQ_DIV0_TRAP_EN enables
// the divide-by-zero trap (forced result and res_err).
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [7:0]       alu_result,
  input  logic             alu_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_carry,
  output logic [2:0]       res_op,
  output logic             res_err,
  output logic [LVL_W-1:0] fifo_level,
  output logic             busy
);

  seq_state_t       state_reg;
  seq_state_t       state_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] head_bits;
  alu_cmd_t         head;
  logic             pop_en;
  logic             capture_en;
  logic             release_en;

  assign cmd_ready = ~fifo_full;
  assign head      = alu_cmd_t'(head_bits);

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid),
    .push_data ({cmd_a, cmd_b, cmd_op}),
    .pop       (pop_en),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!fifo_empty) state_next = ISSUE;
      ISSUE:   state_next = HOLD;
      HOLD:    if (res_ready) state_next = fifo_empty ? IDLE : ISSUE;
      default: state_next = IDLE;
    endcase
  end

  // Pop decisions use the registered FIFO count, so a fresh push is never
  // issued on the same edge it was written.
  always_comb begin
    pop_en     = 1'b0;
    capture_en = 1'b0;
    release_en = 1'b0;
    case (state_reg)
      IDLE:  pop_en = ~fifo_empty;
      ISSUE: capture_en = 1'b1;
      HOLD: begin
        release_en = res_ready;
        pop_en     = res_ready & ~fifo_empty;
      end
      default: ;
    endcase
    busy = (state_reg != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
    end else if (pop_en) begin
      alu_a      <= head.a;
      alu_b      <= head.b;
      alu_opcode <= head.op;
    end
  end

`ifdef ALU_SEQ_DIV0_TRAP_EN
  logic div0;
  assign div0 = is_div0(alu_opcode, alu_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_err <= 1'b0;
    end else if (capture_en) begin
      res_err <= div0;
    end
  end
`else
  logic div0;
  assign div0    = 1'b0;
  assign res_err = 1'b0;
`endif

  // Result capture happens one cycle after issue, once the ALU has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_op    <= '0;
    end else if (capture_en) begin
      res_valid <= 1'b1;
      res_data  <= div0 ? DIV0_RESULT : alu_result;
      res_carry <= div0 ? 1'b0 : alu_carry;
      res_op    <= alu_opcode;
    end else if (release_en) begin
      res_valid <= 1'b0;
    end
  end

endmodule
